mac_array_sequencer: RTL and testbench

Sequences one convolution pass of the MAC array.
- Fetches K*K 5-bit weight slices from weight BRAM into the per-MAC preload shift registers.
- Commits the preloaded weights into the MACs.
- Streams a programmed number of ifmap words from the ifmap FIFO, one per non-empty cycle.
- Sits between the AXI-lite instruction/config registers and the MAC array control block, and drives its load_weight_preload, load_MAC_weight and load_ifmaps strobes.

---
 rtl/mac_ctrl_pkg.sv | 27 ++
 rtl/weight_fetch_agen.sv | 53 +++++
 rtl/mac_array_sequencer.sv | 135 +++++++++++++
 tb/tb_mac_array_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC array control path: sequencer states, kernel
// limits, register-decoder instruction codes and the K*K helper.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FLUSH  = 3'd2,
    S_COMMIT = 3'd3,
    S_STREAM = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  localparam int K_MAX  = 5;
  localparam int NW_MAX = 25;

  localparam logic [7:0] INST_COMPUTE    = 8'd87;
  localparam logic [7:0] INST_LOADIFMAPS = 8'd88;

  // Weight slices per pass; only meaningful for legal K (1..K_MAX).
  function automatic logic [4:0] kernel_nw(input logic [4:0] k);
    logic [9:0] p;
    p = 10'(k) * 10'(k);
    return p[4:0];
  endfunction

endpackage

// File: rtl/weight_fetch_agen.sv
// Weight BRAM address generator with a read-latency delay line that turns each
// read enable into the matching preload strobe.
module weight_fetch_agen #(
  parameter int AW  = 12,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [AW-1:0] i_base,
  input  logic [4:0]    i_nw,
  input  logic          i_fetch,
  input  logic          i_clear,
  output logic [AW-1:0] o_addr,
  output logic          o_rd_en,
  output logic          o_preload,
  output logic          o_last
);

  logic [AW-1:0] r_addr;
  logic [4:0]    r_cnt;
  logic [LAT-1:0] r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_cnt  <= '0;
    end else if (i_fetch) begin
      r_addr <= r_addr + AW'(1);
      r_cnt  <= r_cnt + 5'd1;
    end
  end

  // Clearing on abort drops reads already in flight so no stray preloads follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly <= '0;
    end else if (i_clear) begin
      r_dly <= '0;
    end else begin
      r_dly <= LAT'({r_dly, i_fetch});
    end
  end

  assign o_rd_en   = i_fetch;
  assign o_addr    = i_fetch ? r_addr : '0;
  assign o_last    = i_fetch && (r_cnt == (i_nw - 5'd1));
  assign o_preload = r_dly[LAT-1];

endmodule

// File: rtl/mac_array_sequencer.sv
// Sequences one convolution pass: weight fetch, commit, ifmap streaming.
// Optional SEQ_PERF_CNT_EN adds stall_cycles / pass_cycles counters.
module mac_array_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int BRAM_RD_LATENCY    = 1,
  parameter int WIN_CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [4:0]                    kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
  input  logic [WIN_CNT_WIDTH-1:0]      num_windows,
  input  logic                          ifmaps_fifo_empty,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  output logic                          bram_rd_en,
  output logic                          load_weight_preload,
  output logic                          load_MAC_weight,
  output logic                          load_ifmaps,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output state_e                        dbg_state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   pass_cycles
`endif
);

  localparam logic [1:0] LAT_M1 = 2'(BRAM_RD_LATENCY - 1);

  state_e                     r_state, w_state_next;
  logic [4:0]                 r_nw;
  logic [WIN_CNT_WIDTH-1:0]   r_num_win;
  logic [WIN_CNT_WIDTH-1:0]   r_win;
  logic [1:0]                 r_flush_cnt;
  logic                       r_cfg_err;
  logic                       w_legal, w_start_idle, w_start_legal, w_last;

  assign w_legal       = (kernel_size != 5'd0) && (kernel_size <= 5'(K_MAX));
  assign w_start_idle  = (r_state == S_IDLE) && start && !abort;
  assign w_start_legal = w_start_idle && w_legal;

  weight_fetch_agen #(
    .AW (BRAM_ADDRESS_WIDTH),
    .LAT(BRAM_RD_LATENCY)
  ) u_agen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_start_legal),
    .i_base   (weight_base_addr),
    .i_nw     (r_nw),
    .i_fetch  (r_state == S_FETCH),
    .i_clear  (abort),
    .o_addr   (bram_addr),
    .o_rd_en  (bram_rd_en),
    .o_preload(load_weight_preload),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    load_ifmaps  = 1'b0;
    if (r_state == S_STREAM) load_ifmaps = !ifmaps_fifo_empty;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start_legal) w_state_next = S_FETCH;
        S_FETCH:  if (w_last) w_state_next = S_FLUSH;
        S_FLUSH:  if (r_flush_cnt == LAT_M1) w_state_next = S_COMMIT;
        S_COMMIT: w_state_next = (r_num_win != '0) ? S_STREAM : S_FIN;
        S_STREAM: if (load_ifmaps && ((r_win + WIN_CNT_WIDTH'(1)) == r_num_win))
                    w_state_next = S_FIN;
        S_FIN:    w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nw        <= '0;
      r_num_win   <= '0;
      r_win       <= '0;
      r_flush_cnt <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_start_idle) begin
        r_cfg_err <= !w_legal;
        if (w_legal) begin
          r_nw      <= kernel_nw(kernel_size);
          r_num_win <= num_windows;
          r_win     <= '0;
        end
      end else if (load_ifmaps) begin
        r_win <= r_win + WIN_CNT_WIDTH'(1);
      end
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
    end
  end

  assign load_MAC_weight = (r_state == S_COMMIT);
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_FIN);
  assign cfg_err         = r_cfg_err;
  assign dbg_state       = r_state;

`ifdef SEQ_PERF_CNT_EN
  // pass_cycles includes the start cycle itself; both counters freeze once IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      pass_cycles  <= '0;
    end else if (w_start_legal) begin
      stall_cycles <= '0;
      pass_cycles  <= 32'd1;
    end else if (r_state != S_IDLE) begin
      if (pass_cycles != '1) pass_cycles <= pass_cycles + 32'd1;
      if ((r_state == S_STREAM) && ifmaps_fifo_empty && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer: a timeline model predicts every output
// each cycle, and per-pass literal checks pin the model to hand-computed values.
module tb_mac_array_sequencer;
  import mac_ctrl_pkg::*;

  localparam int AW  = 12;
  localparam int WW  = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [4:0]    kernel_size = '0;
  logic [AW-1:0] weight_base_addr = '0;
  logic [WW-1:0] num_windows = '0;
  logic          ifmaps_fifo_empty = 1'b1;
  logic [AW-1:0] bram_addr;
  logic          bram_rd_en, load_weight_preload, load_MAC_weight, load_ifmaps;
  logic          busy, done, cfg_err;
  state_e        dbg_state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   stall_cycles, pass_cycles;
`endif

  mac_array_sequencer #(
    .BRAM_ADDRESS_WIDTH(AW),
    .BRAM_RD_LATENCY   (LAT),
    .WIN_CNT_WIDTH     (WW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .kernel_size        (kernel_size),
    .weight_base_addr   (weight_base_addr),
    .num_windows        (num_windows),
    .ifmaps_fifo_empty  (ifmaps_fifo_empty),
    .bram_addr          (bram_addr),
    .bram_rd_en         (bram_rd_en),
    .load_weight_preload(load_weight_preload),
    .load_MAC_weight    (load_MAC_weight),
    .load_ifmaps        (load_ifmaps),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err),
    .dbg_state          (dbg_state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .stall_cycles       (stall_cycles),
    .pass_cycles        (pass_cycles)
`endif
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- model and scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  bit m_active = 0;
  bit m_cfg = 0;
  int m_t0, m_nw, m_nwin, m_cnt;
  int m_fin_at = -1;

  int s_rd, s_pre, s_com, s_ld, s_done, s_busy, s_com_cyc, s_done_cyc;
  int ld_q[$];
  int addr_q[$];

  task automatic clear_stats();
    s_rd = 0; s_pre = 0; s_com = 0; s_ld = 0; s_done = 0; s_busy = 0;
    s_com_cyc = -1; s_done_cyc = -1;
    ld_q.delete(); addr_q.delete();
  endtask

  always @(negedge clk) begin
    int d;
    bit e_rd, e_pre, e_com, e_str, e_ld, e_done;
    if (!rst_n) begin
      m_active = 0; m_cfg = 0; m_fin_at = -1;
      exp_q.delete();
    end else begin
      d      = cyc - m_t0;
      e_rd   = m_active && d >= 1 && d <= m_nw;
      e_pre  = m_active && d >= 1 + LAT && d <= m_nw + LAT;
      e_com  = m_active && d == m_nw + LAT + 1;
      e_str  = m_active && d >= m_nw + LAT + 2 && m_fin_at < 0;
      e_ld   = e_str && !ifmaps_fifo_empty;
      e_done = m_active && cyc == m_fin_at;
      check("bram_rd_en", int'(bram_rd_en), int'(e_rd));
      check("preload", int'(load_weight_preload), int'(e_pre));
      check("load_MAC_weight", int'(load_MAC_weight), int'(e_com));
      check("load_ifmaps", int'(load_ifmaps), int'(e_ld));
      check("done", int'(done), int'(e_done));
      check("busy", int'(busy), int'(m_active));
      check("cfg_err", int'(cfg_err), int'(m_cfg));
      if (e_rd && bram_rd_en) begin
        if (exp_q.size() == 0) check("addr_q_empty", 1, 0);
        else check("bram_addr", int'(bram_addr), int'(exp_q.pop_front()));
      end
      if (bram_rd_en) begin s_rd++; addr_q.push_back(int'(bram_addr)); end
      if (load_weight_preload) s_pre++;
      if (load_MAC_weight) begin s_com++; s_com_cyc = cyc; end
      if (load_ifmaps) begin s_ld++; ld_q.push_back(cyc); end
      if (done) begin s_done++; s_done_cyc = cyc; end
      if (busy) s_busy++;
      // advance the model with this cycle's inputs
      if (abort) begin
        m_active = 0; m_fin_at = -1;
        exp_q.delete();
      end else if (!m_active) begin
        if (start) begin
          if (kernel_size >= 1 && kernel_size <= 5) begin
            m_cfg = 0; m_active = 1; m_t0 = cyc; m_cnt = 0;
            m_nw = int'(kernel_size) * int'(kernel_size);
            m_nwin = int'(num_windows);
            m_fin_at = (m_nwin == 0) ? cyc + m_nw + LAT + 2 : -1;
            exp_q.delete();
            for (int i = 0; i < m_nw; i++) exp_q.push_back(AW'(int'(weight_base_addr) + i));
          end else begin
            m_cfg = 1;
          end
        end
      end else begin
        if (e_ld) begin
          m_cnt++;
          if (m_cnt == m_nwin) m_fin_at = cyc + 1;
        end
        if (cyc == m_fin_at) begin m_active = 0; m_fin_at = -1; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic start_pass(input logic [4:0] k, input logic [AW-1:0] base,
                            input logic [WW-1:0] nwin, output int t0);
    @(posedge clk); #1;
    kernel_size = k; weight_base_addr = base; num_windows = nwin;
    start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check(name, int'(i < budget), 1);
    step(2);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t0;
    logic pat [5];
    pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(bram_rd_en), 0);
    check("rst_bram_addr", int'(bram_addr), 0);
    check("rst_strobes", int'({load_weight_preload, load_MAC_weight, load_ifmaps}), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(2);

    // K=3, base 0x010, 4 windows, FIFO always full
    clear_stats(); ifmaps_fifo_empty = 1'b0;
    start_pass(5'd3, 12'h010, 16'd4, t0);
    wait_done("a_wait", 100);
    check("a_reads", s_rd, 9);
    check("a_first_addr", addr_q[0], 'h010);
    check("a_last_addr", addr_q[8], 'h018);
    check("a_preloads", s_pre, 9);
    check("a_commit_lat", s_com_cyc - t0, 11);
    check("a_loads", s_ld, 4);
    check("a_loads_consec", ld_q[3] - ld_q[0], 3);
    check("a_done_after_load", s_done_cyc - ld_q[3], 1);
    check("a_done_count", s_done, 1);

    // K=5, base 0xFF0: address wrap
    clear_stats();
    start_pass(5'd5, 12'hFF0, 16'd2, t0);
    wait_done("b_wait", 100);
    check("b_preloads", s_pre, 25);
    check("b_reads", addr_q.size(), 25);
    check("b_addr_15", addr_q[15], 'hFFF);
    check("b_addr_16", addr_q[16], 'h000);
    check("b_addr_24", addr_q[24], 'h008);

    // K=1, 3 windows with empty pattern 0,1,1,0,0 over STREAM
    clear_stats(); ifmaps_fifo_empty = 1'b1;
    start_pass(5'd1, 12'h100, 16'd3, t0);
    step(3);
    for (int i = 0; i < 5; i++) begin
      ifmaps_fifo_empty = pat[i];
      step(1);
    end
    ifmaps_fifo_empty = 1'b0;
    wait_done("c_wait", 50);
    check("c_loads", ld_q.size(), 3);
    check("c_load0", ld_q[0] - t0, 4);
    check("c_load1", ld_q[1] - t0, 7);
    check("c_load2", ld_q[2] - t0, 8);
    check("c_done", s_done_cyc - t0, 9);
`ifdef SEQ_PERF_CNT_EN
    check("c_stall_cycles", int'(stall_cycles), 2);
    check("c_pass_cycles", int'(pass_cycles), 10);
`endif

    // illegal kernels, then a legal one clears cfg_err
    clear_stats();
    start_pass(5'd0, 12'h000, 16'd1, t0);
    step(2);
    check("d_cfg_err_k0", int'(cfg_err), 1);
    start_pass(5'd6, 12'h000, 16'd1, t0);
    step(2);
    check("d_cfg_err_k6", int'(cfg_err), 1);
    check("d_no_busy", s_busy, 0);
    check("d_no_strobes", s_rd + s_pre + s_com + s_ld + s_done, 0);
    start_pass(5'd2, 12'h020, 16'd1, t0);
    check("d_cfg_err_cleared", int'(cfg_err), 0);
    wait_done("d_wait", 50);

    // K=4 aborted on 7th FETCH cycle; start mid-pass ignored
    clear_stats();
    start_pass(5'd4, 12'h040, 16'd5, t0);
    step(2);
    start = 1'b1; kernel_size = 5'd1;
    step(1);
    start = 1'b0;
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("e_busy_after_abort", int'(busy), 0);
    check("e_preload_after_abort", int'(load_weight_preload), 0);
    step(5);
    check("e_reads", s_rd, 7);
    check("e_preloads", s_pre, 6);
    check("e_commits", s_com, 0);
    check("e_dones", s_done, 0);
    // start and abort together in IDLE: abort wins
    kernel_size = 5'd2; start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    check("e_start_abort_busy", int'(busy), 0);
    step(2);

    // K=2, zero windows
    clear_stats();
    start_pass(5'd2, 12'h0A0, 16'd0, t0);
    wait_done("f_wait", 50);
    check("f_preloads", s_pre, 4);
    check("f_commits", s_com, 1);
    check("f_loads", s_ld, 0);
    check("f_done_after_commit", s_done_cyc - s_com_cyc, 1);

    // asynchronous reset mid-pass
    start_pass(5'd3, 12'h200, 16'd2, t0);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("g_async_busy", int'(busy), 0);
    check("g_async_rd_en", int'(bram_rd_en), 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
